// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the UART register slave.
// One transfer at a time; a watchdog aborts transfers the slave never completes.
module uart_bus_arbiter #(
  parameter int TIMEOUT = 65536,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t         state;
  logic           last;
  logic [TW-1:0]  wdog;

  assign s_addr  = grant ? m1_addr  : m0_addr;
  assign s_wdata = grant ? m1_wdata : m0_wdata;
  assign s_wstrb = grant ? m1_wstrb : m0_wstrb;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      last     <= 1'b1;
      wdog     <= '0;
      grant    <= 1'b0;
      s_valid  <= 1'b0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      timeout  <= 1'b0;
    end else begin
      // Completion strobes live for the single DONE cycle only.
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant   <= (m0_valid && m1_valid) ? !last : m1_valid;
            s_valid <= 1'b1;
            wdog    <= '0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (s_ready) begin
            s_valid <= 1'b0;
            if (grant) begin
              m1_rdata <= s_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= s_rdata;
              m0_ready <= 1'b1;
            end
            state <= DONE;
          end else if (wdog == WD_LAST) begin
            s_valid <= 1'b0;
            timeout <= 1'b1;
            if (grant) begin
              m1_rdata <= 32'hFFFF_FFFF;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= 32'hFFFF_FFFF;
              m0_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          // The finishing master still holds valid here, so requests wait for IDLE.
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: directed master traffic against a
// programmable-latency slave model, completions checked by a negedge monitor.
module tb_uart_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        grant, timeout;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout(timeout)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    bit          to;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  int          nrdy0 = 0;
  int          nrdy1 = 0;

  // Slave model: asserts s_ready on the slave_delay-th cycle s_valid is seen (-1 = never).
  int          slave_delay = 1;
  logic [31:0] slave_xor = '0;
  int          scnt = 0;
  int          vrun = 0;
  int          vlen = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_tx(input int m, input logic [31:0] rd, input bit to);
    exp_t e;
    e.m = m;
    e.rdata = rd;
    e.to = to;
    sb.push_back(e);
  endtask

  // Called at a negedge; lat = negedges from driving valid to observing ready.
  task automatic m_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output int lat);
    bit seen;
    seen = 1'b0;
    if (m == 0) begin
      m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
    end else begin
      m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
    end
    lat = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL req_wait: master %0d got no ready within %0d cycles, expected one", m, lat);
    end
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      if (s_valid) vrun++;
      else begin
        if (vrun > 0) vlen = vrun;
        vrun = 0;
      end
      if (s_ready) s_ready = 1'b0;
      else if (s_valid) begin
        scnt++;
        if (scnt == slave_delay) begin
          s_rdata   = s_addr ^ slave_xor;
          cap_addr  = s_addr;
          cap_wdata = s_wdata;
          cap_wstrb = s_wstrb;
          s_ready   = 1'b1;
        end
      end
      if (!s_valid) scnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m0_ready && m1_ready) begin
      total++;
      $display("FAIL both_ready: m0_ready=1 m1_ready=1, expected at most one");
    end else if (m0_ready || m1_ready) begin
      if (m0_ready) nrdy0++;
      else nrdy1++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready: master %0d ready, expected none", m1_ready);
      end else begin
        e = sb.pop_front();
        chk("ready_master", {31'b0, m1_ready}, 32'(e.m));
        chk("grant", {31'b0, grant}, 32'(e.m));
        chk("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
        chk("timeout_flag", {31'b0, timeout}, {31'b0, e.to});
      end
    end else if (timeout) begin
      total++;
      $display("FAIL timeout_alone: timeout=1 without ready, expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int la, lb, r0, r1;
    resetn = 1'b0;
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_grant", {31'b0, grant}, 32'd0);

    // Collision straight out of reset, both masters requesting continuously.
    resetn = 1'b1;
    slave_delay = 1;
    slave_xor = 32'h0000_00F0;
    expect_tx(0, 32'h8002_0000 ^ 32'h0000_00F0, 1'b0);
    expect_tx(1, 32'h8002_0010 ^ 32'h0000_00F0, 1'b0);
    expect_tx(0, 32'h8002_0004 ^ 32'h0000_00F0, 1'b0);
    expect_tx(1, 32'h8002_0014 ^ 32'h0000_00F0, 1'b0);
    fork
      begin
        m_req(0, 32'h8002_0000, 32'h1, 4'h1, la);
        m_req(0, 32'h8002_0004, 32'h2, 4'h1, la);
      end
      begin
        m_req(1, 32'h8002_0010, 32'h3, 4'h1, lb);
        m_req(1, 32'h8002_0014, 32'h4, 4'h1, lb);
      end
    join
    @(negedge clk);

    // Single write from master 0.
    r0 = nrdy0; r1 = nrdy1;
    slave_xor = 32'h8002_0004 ^ 32'h0000_0011;
    expect_tx(0, 32'h0000_0011, 1'b0);
    m_req(0, 32'h8002_0004, 32'h0000_0041, 4'hF, la);
    repeat (2) @(negedge clk);
    chk("single_latency", 32'(la), 32'd2);
    chk("single_s_addr", cap_addr, 32'h8002_0004);
    chk("single_s_wdata", cap_wdata, 32'h0000_0041);
    chk("single_s_wstrb", {28'b0, cap_wstrb}, 32'hF);
    chk("single_m0_pulses", 32'(nrdy0 - r0), 32'd1);
    chk("single_m1_pulses", 32'(nrdy1 - r1), 32'd0);

    // Read from master 1; master 0 data must hold.
    slave_delay = 3;
    slave_xor = 32'h8002_0008 ^ 32'h0000_005A;
    expect_tx(1, 32'h0000_005A, 1'b0);
    m_req(1, 32'h8002_0008, 32'h0, 4'h0, lb);
    @(negedge clk);
    chk("read_latency", 32'(lb), 32'd4);
    chk("read_m1_rdata_hold", m1_rdata, 32'h0000_005A);
    chk("read_m0_rdata_hold", m0_rdata, 32'h0000_0011);

    // Slave stalls forever: watchdog abort.
    slave_delay = -1;
    expect_tx(0, 32'hFFFF_FFFF, 1'b1);
    m_req(0, 32'h8002_0004, 32'h55, 4'h1, la);
    @(negedge clk);
    chk("stall_latency", 32'(la), 32'(TO + 1));
    chk("stall_valid_len", 32'(vlen), 32'(TO));
    chk("stall_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
    slave_delay = 2;
    slave_xor = 32'h8002_0010 ^ 32'h0000_0077;
    expect_tx(1, 32'h0000_0077, 1'b0);
    m_req(1, 32'h8002_0010, 32'h0, 4'h0, lb);
    chk("after_stall_latency", 32'(lb), 32'd3);

    // s_ready arrives exactly when the watchdog reaches its last count.
    @(negedge clk);
    slave_delay = TO;
    slave_xor = 32'h8002_0004 ^ 32'h0000_0033;
    expect_tx(0, 32'h0000_0033, 1'b0);
    m_req(0, 32'h8002_0004, 32'h66, 4'h3, la);
    @(negedge clk);
    chk("limit_latency", 32'(la), 32'(TO + 1));
    chk("limit_valid_len", 32'(vlen), 32'(TO));

    // Reset in the middle of a stalled transfer.
    slave_delay = -1;
    m0_addr = 32'h8002_0004; m0_wdata = 32'h99; m0_wstrb = 4'hF; m0_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_s_valid_before", {31'b0, s_valid}, 32'd1);
    r0 = nrdy0; r1 = nrdy1;
    resetn = 1'b0;
    m0_valid = 1'b0;
    @(negedge clk);
    chk("midrst_s_valid_after", {31'b0, s_valid}, 32'd0);
    chk("midrst_m0_rdata", m0_rdata, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_ready0", 32'(nrdy0 - r0), 32'd0);
    chk("midrst_no_ready1", 32'(nrdy1 - r1), 32'd0);
    slave_delay = 1;
    slave_xor = '0;
    expect_tx(1, 32'h8002_0020, 1'b0);
    expect_tx(0, 32'h8002_0024, 1'b0);
    fork
      m_req(1, 32'h8002_0020, 32'h0, 4'h0, lb);
      begin
        @(negedge clk);
        m_req(0, 32'h8002_0024, 32'h0, 4'h0, la);
      end
    join

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
